// File: rtl/mem_store_pkg.sv
// Shared constants for the commit-side store writer: op codes, FSM encoding, IO addresses.
// Op-id width and SB/SH/SW/ADD codes mirror the project-wide defines.
package mem_store_pkg;

  localparam int OP_ID_W = 6;

  localparam logic [OP_ID_W-1:0] OP_ADD = 6'd1;
  localparam logic [OP_ID_W-1:0] OP_SB  = 6'd18;
  localparam logic [OP_ID_W-1:0] OP_SH  = 6'd19;
  localparam logic [OP_ID_W-1:0] OP_SW  = 6'd20;

  // UART data and status registers; byte writes here may be throttled.
  localparam logic [31:0] IO_ADDR_TX   = 32'h0003_0000;
  localparam logic [31:0] IO_ADDR_STAT = 32'h0003_0004;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic is_store(input logic [OP_ID_W-1:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Index of the last byte to write: SB=0, SH=1, SW=3.
  function automatic logic [1:0] last_byte(input logic [OP_ID_W-1:0] op);
    case (op)
      OP_SB:   return 2'd0;
      OP_SH:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_store_writer_if.sv
// ROB commit, arbiter handshake and RAM byte-bus signals of the store writer.
// master = the store writer, slave = its environment (ROB, LSB, arbiter, RAM).
interface mem_store_writer_if #(parameter int ADDR_W = 32);
  import mem_store_pkg::*;

  logic               ROB_input_valid;
  logic [OP_ID_W-1:0] ROB_OP_ID;
  logic [31:0]        ROB_value;
  logic [ADDR_W-1:0]  ROB_addr;
  logic               ROB_store_full;
  logic               LSB_store_empty;
  logic               ARB_req;
  logic               ARB_grant;
  logic [ADDR_W-1:0]  mem_a;
  logic [7:0]         mem_dout;
  logic               mem_wr;
  logic               io_buffer_full;
  logic               store_overflow;

  modport master (
    input  ROB_input_valid, ROB_OP_ID, ROB_value, ROB_addr, ARB_grant, io_buffer_full,
    output ROB_store_full, LSB_store_empty, ARB_req, mem_a, mem_dout, mem_wr, store_overflow
  );

  modport slave (
    output ROB_input_valid, ROB_OP_ID, ROB_value, ROB_addr, ARB_grant, io_buffer_full,
    input  ROB_store_full, LSB_store_empty, ARB_req, mem_a, mem_dout, mem_wr, store_overflow
  );

endinterface

// File: rtl/store_fifo.sv
// In-order synchronous FIFO holding committed store entries; DEPTH must be a power of two >= 2.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module store_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_en && i_pop && !o_empty;
  assign w_do_push = i_en && i_push && (!o_full || w_do_pop);

  // Pointers are PTR_W bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage has no reset; validity is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/mem_store_writer.sv
// Commit-side store engine: buffers SB/SH/SW entries and writes them byte-wise, little-endian.
// Optional MEM_STORE_IO_THROTTLE_EN: stall UART-address bytes while io_buffer_full is high.
module mem_store_writer
  import mem_store_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input logic                clk,
  input logic                rst,
  input logic                rdy,
  mem_store_writer_if.master bus
);

  localparam int ENT_W = OP_ID_W + ADDR_W + 32;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_t              r_state;
  logic [1:0]          r_k;
  logic [1:0]          r_last;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_value;
  logic                r_arb_req;
  logic                r_mem_wr;
  logic [ADDR_W-1:0]   r_mem_a;
  logic [7:0]          r_mem_dout;
  logic                r_overflow;

  logic                w_push_req;
  logic                w_pop;
  logic                w_stall;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [CNT_W-1:0]    w_fifo_count;
  logic [ENT_W-1:0]    w_push_data;
  logic [ENT_W-1:0]    w_head;
  logic [OP_ID_W-1:0]  w_head_op;
  logic [ADDR_W-1:0]   w_head_addr;
  logic [31:0]         w_head_value;
  logic [1:0]          w_next_k;

  assign w_push_req   = bus.ROB_input_valid && is_store(bus.ROB_OP_ID);
  assign w_push_data  = {bus.ROB_OP_ID, bus.ROB_addr, bus.ROB_value};
  assign w_head_op    = w_head[ENT_W-1 -: OP_ID_W];
  assign w_head_addr  = w_head[32 +: ADDR_W];
  assign w_head_value = w_head[31:0];
  assign w_next_k     = r_k + 2'd1;
  assign w_pop        = (r_state == ST_WRITE) && (r_k == r_last) && !w_stall;

`ifdef MEM_STORE_IO_THROTTLE_EN
  assign w_stall = (r_state == ST_WRITE) && bus.io_buffer_full &&
                   ((r_mem_a == ADDR_W'(IO_ADDR_TX)) || (r_mem_a == ADDR_W'(IO_ADDR_STAT)));
`else
  logic w_io_full_unused;
  assign w_io_full_unused = bus.io_buffer_full;
  assign w_stall          = 1'b0;
`endif

  store_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_en    (rdy),
    .i_push  (w_push_req),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign bus.ROB_store_full  = w_fifo_full;
  assign bus.LSB_store_empty = (w_fifo_count == '0) && (r_state == ST_IDLE);
  assign bus.ARB_req         = r_arb_req;
  assign bus.mem_a           = r_mem_a;
  assign bus.mem_dout        = r_mem_dout;
  assign bus.mem_wr          = r_mem_wr && !w_stall;
  assign bus.store_overflow  = r_overflow;

  // Bus outputs are registered one step ahead: the edge that picks byte k+1 also drives it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_k        <= '0;
      r_last     <= '0;
      r_addr     <= '0;
      r_value    <= '0;
      r_arb_req  <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_mem_a    <= '0;
      r_mem_dout <= '0;
      r_overflow <= 1'b0;
    end else if (rdy) begin
      if (w_push_req && w_fifo_full && !w_pop) r_overflow <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (!w_fifo_empty) begin
            r_state   <= ST_REQ;
            r_arb_req <= 1'b1;
          end
        end
        ST_REQ: begin
          if (bus.ARB_grant) begin
            r_addr     <= w_head_addr;
            r_value    <= w_head_value;
            r_last     <= last_byte(w_head_op);
            r_k        <= 2'd0;
            r_mem_a    <= w_head_addr;
            r_mem_dout <= w_head_value[7:0];
            r_mem_wr   <= 1'b1;
            r_state    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (!w_stall) begin
            if (r_k == r_last) begin
              r_mem_wr  <= 1'b0;
              r_arb_req <= 1'b0;
              r_state   <= ST_DONE;
            end else begin
              r_k        <= w_next_k;
              r_mem_a    <= r_addr + ADDR_W'(w_next_k);
              r_mem_dout <= r_value[{w_next_k, 3'b000} +: 8];
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_store_writer.sv
// Scoreboard bench for mem_store_writer: expected byte writes are queued at push time
// and checked by a bus monitor; per-scenario tasks check handshake timing and flags.
module tb_mem_store_writer;
  import mem_store_pkg::*;

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  logic clk;
  logic rst;
  logic rdy;
  logic grant_en;
  int   checks;
  int   errors;
  wr_t  exp_q[$];

  mem_store_writer_if #(.ADDR_W(32)) bus ();

  mem_store_writer #(
    .DEPTH  (4),
    .ADDR_W (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arbiter model: grant follows request one cycle later while enabled.
  initial begin
    bus.ARB_grant = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.ARB_grant = grant_en && bus.ARB_req;
    end
  end

  // RAM-side monitor: each accepted byte write must match the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.mem_wr === 1'b1 && rdy === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got a=%h d=%h, required no write", bus.mem_a, bus.mem_dout);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if (bus.mem_a !== e.a || bus.mem_dout !== e.d) begin
            errors++;
            $display("FAIL write_data: got a=%h d=%h, required a=%h d=%h",
                     bus.mem_a, bus.mem_dout, e.a, e.d);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
  endtask

  // Drive one commit for a cycle; enqueue the first n_exp expected bytes.
  task automatic drive_push(input logic [OP_ID_W-1:0] op, input logic [31:0] addr,
                            input logic [31:0] val, input int n_exp);
    wr_t e;
    bus.ROB_input_valid = 1'b1;
    bus.ROB_OP_ID       = op;
    bus.ROB_addr        = addr;
    bus.ROB_value       = val;
    for (int k = 0; k < n_exp; k++) begin
      e.a = addr + 32'(k);
      e.d = val[8*k +: 8];
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.ROB_input_valid = 1'b0;
    bus.ROB_OP_ID       = OP_ADD;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (bus.LSB_store_empty === 1'b1 && bus.ARB_req === 1'b0 && exp_q.size() == 0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain: got %0d bytes pending empty=%b, required 0 pending empty=1",
               name, exp_q.size(), bus.LSB_store_empty);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks += 7;
    if (bus.ARB_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b required 0", bus.ARB_req); end
    if (bus.mem_wr !== 1'b0) begin errors++; $display("FAIL rst_wr: got %b required 0", bus.mem_wr); end
    if (bus.mem_a !== 32'h0) begin errors++; $display("FAIL rst_a: got %h required 0", bus.mem_a); end
    if (bus.mem_dout !== 8'h0) begin errors++; $display("FAIL rst_dout: got %h required 0", bus.mem_dout); end
    if (bus.store_overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b required 0", bus.store_overflow); end
    if (bus.ROB_store_full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b required 0", bus.ROB_store_full); end
    if (bus.LSB_store_empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b required 1", bus.LSB_store_empty); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_sw();
    int first_wr, last_wr, n_wr, idle_at;
    first_wr = -1; last_wr = -1; n_wr = 0; idle_at = -1;
    grant_en = 1'b1;
    drive_push(OP_SW, 32'h1000, 32'hDEADBEEF, 4);
    for (int o = 0; o < 20; o++) begin
      @(negedge clk);
      if (o == 0) begin
        checks += 2;
        if (bus.ARB_req !== 1'b0) begin errors++; $display("FAIL sw_req_early: got %b required 0", bus.ARB_req); end
        if (bus.LSB_store_empty !== 1'b0) begin errors++; $display("FAIL sw_empty_fall: got %b required 0", bus.LSB_store_empty); end
      end
      if (o == 1) begin
        checks++;
        if (bus.ARB_req !== 1'b1) begin errors++; $display("FAIL sw_req_rise: got %b required 1", bus.ARB_req); end
      end
      if (bus.mem_wr === 1'b1) begin
        if (first_wr < 0) first_wr = o;
        last_wr = o;
        n_wr++;
      end
      if (bus.LSB_store_empty === 1'b1 && idle_at < 0) idle_at = o;
    end
    checks += 4;
    if (first_wr != 2) begin errors++; $display("FAIL sw_first_byte: got cycle %0d required 2", first_wr); end
    if (last_wr != 5) begin errors++; $display("FAIL sw_last_byte: got cycle %0d required 5", last_wr); end
    if (n_wr != 4) begin errors++; $display("FAIL sw_byte_count: got %0d required 4", n_wr); end
    if (idle_at != 7) begin errors++; $display("FAIL sw_idle_cycle: got %0d required 7", idle_at); end
    @(posedge clk);
    #1;
    wait_idle("sw");
  endtask

  task automatic test_io_throttle();
    int wr_while_full, exp_while_full;
`ifdef MEM_STORE_IO_THROTTLE_EN
    exp_while_full = 0;
`else
    exp_while_full = 1;
`endif
    wr_while_full = 0;
    grant_en = 1'b1;
    bus.io_buffer_full = 1'b1;
    drive_push(OP_SB, 32'h0003_0000, 32'h0000_0041, 1);
    for (int o = 0; o < 3; o++) begin
      @(negedge clk);
      if (bus.mem_wr === 1'b1) wr_while_full++;
    end
    @(posedge clk);
    #1 bus.io_buffer_full = 1'b0;
    checks++;
    if (wr_while_full != exp_while_full) begin
      errors++;
      $display("FAIL io_throttle: got %0d writes while full, required %0d", wr_while_full, exp_while_full);
    end
    wait_idle("io");
  endtask

  task automatic test_rdy_hold();
    bit seen;
    seen = 1'b0;
    grant_en = 1'b1;
    drive_push(OP_SW, 32'h3000, 32'h11223344, 4);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_wr === 1'b1 && bus.mem_a === 32'h3001) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rdy_wait: got no byte 1, required byte 1 at 3001"); end
    @(posedge clk);
    #1 rdy = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks += 2;
      if (bus.mem_wr !== 1'b1) begin errors++; $display("FAIL rdy_hold_wr: got %b required 1", bus.mem_wr); end
      if (bus.mem_a !== 32'h3002 || bus.mem_dout !== 8'h22) begin
        errors++;
        $display("FAIL rdy_hold_bus: got a=%h d=%h required a=3002 d=22", bus.mem_a, bus.mem_dout);
      end
    end
    @(posedge clk);
    #1 rdy = 1'b1;
    wait_idle("rdy");
  endtask

  task automatic test_full_overflow();
    grant_en = 1'b0;
    for (int i = 0; i < 4; i++)
      drive_push(OP_SH, 32'h4000 + 32'(4 * i), 32'h0000_A0B0 + 32'(i), 2);
    @(negedge clk);
    checks += 2;
    if (bus.ROB_store_full !== 1'b1) begin errors++; $display("FAIL full_after4: got %b required 1", bus.ROB_store_full); end
    if (bus.store_overflow !== 1'b0) begin errors++; $display("FAIL ovf_before: got %b required 0", bus.store_overflow); end
    @(posedge clk);
    #1;
    drive_push(OP_SH, 32'h4100, 32'h0000_5555, 0);
    @(negedge clk);
    checks += 2;
    if (bus.store_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b required 1", bus.store_overflow); end
    if (bus.ROB_store_full !== 1'b1) begin errors++; $display("FAIL full_hold: got %b required 1", bus.ROB_store_full); end
    @(posedge clk);
    #1 grant_en = 1'b1;
    wait_idle("full");
    checks++;
    if (bus.store_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b required 1", bus.store_overflow); end
  endtask

  task automatic test_push_while_full();
    bit seen;
    do_reset();
    grant_en = 1'b0;
    for (int i = 0; i < 4; i++)
      drive_push(OP_SB, 32'h500 + 32'(i), 32'h0000_00A0 + 32'(i), 1);
    @(negedge clk);
    checks++;
    if (bus.ROB_store_full !== 1'b1) begin errors++; $display("FAIL pwf_full: got %b required 1", bus.ROB_store_full); end
    grant_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_wr === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL pwf_wait: got no head write, required one"); end
    drive_push(OP_SW, 32'h600, 32'hCAFEF00D, 4);
    @(negedge clk);
    checks += 2;
    if (bus.store_overflow !== 1'b0) begin errors++; $display("FAIL pwf_ovf: got %b required 0", bus.store_overflow); end
    if (bus.ROB_store_full !== 1'b1) begin errors++; $display("FAIL pwf_count: got full=%b required 1", bus.ROB_store_full); end
    @(posedge clk);
    #1;
    wait_idle("pwf");
  endtask

  task automatic test_non_store();
    drive_push(OP_ADD, 32'h700, 32'h1234_5678, 0);
    @(negedge clk);
    checks++;
    if (bus.LSB_store_empty !== 1'b1) begin errors++; $display("FAIL add_empty: got %b required 1", bus.LSB_store_empty); end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.ARB_req !== 1'b0) begin errors++; $display("FAIL add_req: got %b required 0", bus.ARB_req); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_write();
    bit seen;
    grant_en = 1'b1;
    drive_push(OP_SW, 32'h2000, 32'h8765_4321, 3);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_wr === 1'b1 && bus.mem_a === 32'h2002) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rmw_wait: got no byte 2, required byte 2 at 2002"); end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks += 3;
    if (bus.mem_wr !== 1'b0) begin errors++; $display("FAIL rmw_wr: got %b required 0", bus.mem_wr); end
    if (bus.ARB_req !== 1'b0) begin errors++; $display("FAIL rmw_req: got %b required 0", bus.ARB_req); end
    if (bus.LSB_store_empty !== 1'b1) begin errors++; $display("FAIL rmw_empty: got %b required 1", bus.LSB_store_empty); end
    repeat (10) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rmw_bytes: got %0d pending, required 0", exp_q.size()); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    rdy = 1'b1;
    grant_en = 1'b0;
    bus.ROB_input_valid = 1'b0;
    bus.ROB_OP_ID       = OP_ADD;
    bus.ROB_value       = '0;
    bus.ROB_addr        = '0;
    bus.io_buffer_full  = 1'b0;

    test_reset();
    test_sw();
    test_io_throttle();
    test_rdy_hold();
    test_full_overflow();
    test_push_while_full();
    test_non_store();
    test_reset_mid_write();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
